dfe_core_ctrl: RTL and testbench
================================

Name: dfe_core_ctrl

Overview:
- Run-time configuration and sequencing controller for the DFE core (fractional decimator -> IIR notch chain -> CIC).
- Accepts a new configuration request (bypass bits, CIC decimation factor), gates input samples and waits for the pipeline to drain. Then pulses a filter-state flush, applies the configuration atomically and re-opens the input.
- Also owns sticky overflow/underflow status for the core.
- Sits between the sample source / control interface and the core's valid_in, rst_n and configuration inputs.

Parameters:
- DEC_WIDTH, 4, CIC decimation-factor width minus one; factor bus is DEC_WIDTH+1 bits.
- MAX_DEC_FACTOR, 16, largest legal CIC decimation factor.
- DEFAULT_DEC, 1, CIC decimation factor applied at reset.
- DRAIN_CYCLES, 64, consecutive cycles with core_valid_out low that define "drained".
- FLUSH_CYCLES, 4, cycles core_rst_n is held low during apply.
- CNT_WIDTH, $clog2(DRAIN_CYCLES+1), derived width of the shared counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- src_valid  in  1  upstream sample valid
- src_ready  out  1  high when the controller passes samples to the core
- core_valid_in  out  1  src_valid & src_ready, drives core valid_in
- core_valid_out  in  1  core output valid, used for drain detection
- core_overflow  in  1  OR of core overflow flags
- core_underflow  in  1  OR of core underflow flags
- core_rst_n  out  1  synchronous active-low reset to core (AND of rst_n and flush)
- cfg_commit  in  1  single-cycle request to apply the cfg_* inputs
- cfg_frac_dec_bypass, cfg_iir_bypass_5MHz, cfg_iir_bypass_2_4MHz, cfg_cic_bypass  in  1 each  requested bypass bits
- cfg_cic_dec_factor  in  DEC_WIDTH+1  requested decimation factor
- frac_dec_bypass, iir_bypass_5MHz, iir_bypass_2_4MHz, cic_bypass  out  1 each  applied bypass bits to core
- cic_dec_factor  out  DEC_WIDTH+1  applied decimation factor
- cfg_busy  out  1  high while a commit is in progress
- cfg_done  out  1  one-cycle pulse when a commit completes
- cfg_err  out  1  one-cycle pulse on a rejected commit
- sts_clr  in  1  clears sticky status
- ovf_sticky, unf_sticky  out  1 each  sticky overflow/underflow

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; src_ready=1; core_valid_in=0; core_rst_n=0 while rst_n=0; all applied bypass bits=0; cic_dec_factor=DEFAULT_DEC; cfg_busy=0, cfg_done=0, cfg_err=0; ovf_sticky=0, unf_sticky=0; counter=0.
- Reset mid-operation aborts any commit. The applied configuration returns to reset values, not to the pending request.
- FSM states:
  - IDLE: src_ready=1.
    - cfg_commit with legal factor (1..MAX_DEC_FACTOR): latch cfg_* into pending registers, go to DRAIN, cfg_busy=1 from the next cycle.
    - Illegal factor (0 or >MAX_DEC_FACTOR): cfg_err pulses the next cycle, state stays IDLE, nothing latched.
  - DRAIN: src_ready=0.
    - Counter increments each cycle core_valid_out=0 and clears to 0 whenever core_valid_out=1.
    - When counter reaches DRAIN_CYCLES-1 with core_valid_out=0, go to FLUSH, counter cleared.
  - FLUSH: core_rst_n=0 and src_ready=0 for exactly FLUSH_CYCLES cycles.
    - Applied configuration outputs load from the pending registers on the first FLUSH cycle. They are stable for the remainder of the flush.
    - Then go to RELEASE.
  - RELEASE: one cycle, core_rst_n=1, src_ready=0. cfg_done pulses this cycle. Return to IDLE; cfg_busy falls on entry to IDLE.
- cfg_commit outside IDLE: ignored, cfg_err pulses next cycle, the pending request is unchanged.
- cfg_commit on the same cycle RELEASE exits: treated as outside IDLE (rejected).
- core_valid_in = src_valid & src_ready, purely combinational. No sample is accepted or dropped silently: src_ready low means the upstream must hold.
- Sticky status: set on any cycle core_overflow/core_underflow=1, cleared by sts_clr. A simultaneous set and clear leaves the flag at 1.
- Sticky bits are not set during FLUSH or RELEASE, because core flags are invalid under flush.
- Configuration outputs change only on the first FLUSH cycle or at reset, never while samples are flowing.

Decomposition:
- Package dfe_ctrl_pkg:
  - state enum (IDLE, DRAIN, FLUSH, RELEASE)
  - struct dfe_cfg_t {frac_dec_bypass, iir_bypass_5MHz, iir_bypass_2_4MHz, cic_bypass, cic_dec_factor}
  - MAX_DEC_FACTOR constant and DEFAULT_DEC constant
  - legal-factor check function
- One natural sub-module: dfe_sticky_status, holding the two sticky flags with clear and mask.
- The FSM and counter stay in dfe_core_ctrl.

Test Plan:
- Reset release: src_valid=1 with no commit -> core_valid_in=1 immediately, cic_dec_factor=1, all bypass=0, sticky flags=0.
- Commit with factor 8 and cic_bypass=1, core_valid_out toggling for 20 cycles then idle -> src_ready low the cycle after commit, then 64 quiet cycles, then core_rst_n low 4 cycles. cic_dec_factor=8 from the first flush cycle, cfg_done 1 cycle, src_ready high after.
- core_valid_out pulse at drain count 50 -> counter restarts; FLUSH begins only after 64 further quiet cycles.
- Commit with factor 0 and factor 17 -> cfg_err pulse each time, state stays IDLE, outputs unchanged, src_ready stays 1.
- Commit during DRAIN with factor 2 -> cfg_err pulse; the originally requested factor is the one applied.
- core_overflow pulse simultaneous with sts_clr -> ovf_sticky=1. sts_clr alone next cycle -> 0. Overflow during FLUSH -> ovf_sticky stays 0.
- rst_n low during FLUSH -> next cycle IDLE, factor=DEFAULT_DEC, cfg_busy=0, no cfg_done.

Source files
------------

// File: rtl/dfe_ctrl_pkg.sv
// Shared types and constants for the DFE core configuration/sequencing controller.
package dfe_ctrl_pkg;

    localparam int DEC_WIDTH      = 4;
    localparam int MAX_DEC_FACTOR = 16;
    localparam int DEFAULT_DEC    = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        FLUSH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef struct packed {
        logic                 frac_dec_bypass;
        logic                 iir_bypass_5MHz;
        logic                 iir_bypass_2_4MHz;
        logic                 cic_bypass;
        logic [DEC_WIDTH:0]   cic_dec_factor;
    } dfe_cfg_t;

    // A factor of zero would stall the CIC forever; above the max the integrators overflow.
    function automatic logic factor_legal(input logic [DEC_WIDTH:0] f, input int max_f);
        return (f != '0) && (int'(f) <= max_f);
    endfunction

endpackage

// File: rtl/dfe_sticky_status.sv
// Sticky overflow/underflow flags; set wins over clear, and setting is masked while the core is flushed.
module dfe_sticky_status (
    input  logic clk,
    input  logic rst_n,
    input  logic mask,
    input  logic clr,
    input  logic overflow,
    input  logic underflow,
    output logic ovf_sticky,
    output logic unf_sticky
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~clr) | (overflow & ~mask);
            unf_sticky <= (unf_sticky & ~clr) | (underflow & ~mask);
        end
    end

endmodule

// File: rtl/dfe_core_ctrl.sv
// Run-time configuration sequencer for the DFE core: gate input, drain, flush, apply config, reopen.
// Handshake: a sample transfers on a cycle where src_valid and src_ready are both high; upstream holds otherwise.
module dfe_core_ctrl
    import dfe_ctrl_pkg::*;
#(
    parameter int DEC_WIDTH      = dfe_ctrl_pkg::DEC_WIDTH,
    parameter int MAX_DEC_FACTOR = dfe_ctrl_pkg::MAX_DEC_FACTOR,
    parameter int DEFAULT_DEC    = dfe_ctrl_pkg::DEFAULT_DEC,
    parameter int DRAIN_CYCLES   = 64,
    parameter int FLUSH_CYCLES   = 4,
    parameter int CNT_WIDTH      = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               core_valid_in,
    input  logic               core_valid_out,
    input  logic               core_overflow,
    input  logic               core_underflow,
    output logic               core_rst_n,
    input  logic               cfg_commit,
    input  logic               cfg_frac_dec_bypass,
    input  logic               cfg_iir_bypass_5MHz,
    input  logic               cfg_iir_bypass_2_4MHz,
    input  logic               cfg_cic_bypass,
    input  logic [DEC_WIDTH:0] cfg_cic_dec_factor,
    output logic               frac_dec_bypass,
    output logic               iir_bypass_5MHz,
    output logic               iir_bypass_2_4MHz,
    output logic               cic_bypass,
    output logic [DEC_WIDTH:0] cic_dec_factor,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_err,
    input  logic               sts_clr,
    output logic               ovf_sticky,
    output logic               unf_sticky,
    output state_t             dbg_state
);

    localparam logic [DEC_WIDTH:0] DEFAULT_FACTOR = DEFAULT_DEC[DEC_WIDTH:0];
    localparam dfe_cfg_t RESET_CFG = '{
        frac_dec_bypass:   1'b0,
        iir_bypass_5MHz:   1'b0,
        iir_bypass_2_4MHz: 1'b0,
        cic_bypass:        1'b0,
        cic_dec_factor:    DEFAULT_FACTOR
    };
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    dfe_cfg_t             pending_cfg, applied_cfg, req_cfg;
    logic                 latch_pending, load_applied, err_next, cfg_err_q;

    assign req_cfg = '{
        frac_dec_bypass:   cfg_frac_dec_bypass,
        iir_bypass_5MHz:   cfg_iir_bypass_5MHz,
        iir_bypass_2_4MHz: cfg_iir_bypass_2_4MHz,
        cic_bypass:        cfg_cic_bypass,
        cic_dec_factor:    cfg_cic_dec_factor
    };

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pending_cfg <= RESET_CFG;
            applied_cfg <= RESET_CFG;
            cfg_err_q   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cfg_err_q <= err_next;
            if (latch_pending) pending_cfg <= req_cfg;
            if (load_applied)  applied_cfg <= pending_cfg;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        latch_pending = 1'b0;
        load_applied  = 1'b0;
        err_next      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_commit) begin
                    if (factor_legal(cfg_cic_dec_factor, MAX_DEC_FACTOR)) begin
                        latch_pending = 1'b1;
                        state_next    = DRAIN;
                        cnt_next      = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                err_next = cfg_commit;
                if (core_valid_out) begin
                    cnt_next = '0;
                end else if (cnt == DRAIN_LAST) begin
                    // Load on the transition edge so the new config is visible in the first FLUSH cycle.
                    state_next   = FLUSH;
                    cnt_next     = '0;
                    load_applied = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            FLUSH: begin
                err_next = cfg_commit;
                if (cnt == FLUSH_LAST) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            RELEASE: begin
                err_next   = cfg_commit;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign src_ready         = (state == IDLE);
    assign core_valid_in     = src_valid & src_ready;
    assign core_rst_n        = rst_n & (state != FLUSH);
    assign cfg_busy          = (state != IDLE);
    assign cfg_done          = (state == RELEASE);
    assign cfg_err           = cfg_err_q;
    assign dbg_state         = state;
    assign frac_dec_bypass   = applied_cfg.frac_dec_bypass;
    assign iir_bypass_5MHz   = applied_cfg.iir_bypass_5MHz;
    assign iir_bypass_2_4MHz = applied_cfg.iir_bypass_2_4MHz;
    assign cic_bypass        = applied_cfg.cic_bypass;
    assign cic_dec_factor    = applied_cfg.cic_dec_factor;

    dfe_sticky_status u_sticky (
        .clk        (clk),
        .rst_n      (rst_n),
        .mask       ((state == FLUSH) || (state == RELEASE)),
        .clr        (sts_clr),
        .overflow   (core_overflow),
        .underflow  (core_underflow),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky)
    );

endmodule

// File: tb/tb_dfe_core_ctrl.sv
// Directed bench for dfe_core_ctrl: reset, commit sequencing, drain restart, rejects, sticky status, abort.
module tb_dfe_core_ctrl;
    import dfe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       src_valid, src_ready, core_valid_in, core_valid_out;
    logic       core_overflow, core_underflow, core_rst_n, cfg_commit;
    logic       cfg_frac_dec_bypass, cfg_iir_bypass_5MHz, cfg_iir_bypass_2_4MHz, cfg_cic_bypass;
    logic [4:0] cfg_cic_dec_factor;
    logic       frac_dec_bypass, iir_bypass_5MHz, iir_bypass_2_4MHz, cic_bypass;
    logic [4:0] cic_dec_factor;
    logic       cfg_busy, cfg_done, cfg_err, sts_clr, ovf_sticky, unf_sticky;
    state_t     dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    dfe_core_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .src_valid             (src_valid),
        .src_ready             (src_ready),
        .core_valid_in         (core_valid_in),
        .core_valid_out        (core_valid_out),
        .core_overflow         (core_overflow),
        .core_underflow        (core_underflow),
        .core_rst_n            (core_rst_n),
        .cfg_commit            (cfg_commit),
        .cfg_frac_dec_bypass   (cfg_frac_dec_bypass),
        .cfg_iir_bypass_5MHz   (cfg_iir_bypass_5MHz),
        .cfg_iir_bypass_2_4MHz (cfg_iir_bypass_2_4MHz),
        .cfg_cic_bypass        (cfg_cic_bypass),
        .cfg_cic_dec_factor    (cfg_cic_dec_factor),
        .frac_dec_bypass       (frac_dec_bypass),
        .iir_bypass_5MHz       (iir_bypass_5MHz),
        .iir_bypass_2_4MHz     (iir_bypass_2_4MHz),
        .cic_bypass            (cic_bypass),
        .cic_dec_factor        (cic_dec_factor),
        .cfg_busy              (cfg_busy),
        .cfg_done              (cfg_done),
        .cfg_err               (cfg_err),
        .sts_clr               (sts_clr),
        .ovf_sticky            (ovf_sticky),
        .unf_sticky            (unf_sticky),
        .dbg_state             (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1ns after the edge, outputs checked 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic commit(input logic [4:0] factor, input logic cbyp);
        cfg_commit         = 1'b1;
        cfg_cic_dec_factor = factor;
        cfg_cic_bypass     = cbyp;
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dbg_state), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; src_valid = 1'b0; core_valid_out = 1'b0;
        core_overflow = 1'b0; core_underflow = 1'b0; cfg_commit = 1'b0;
        cfg_frac_dec_bypass = 1'b0; cfg_iir_bypass_5MHz = 1'b0;
        cfg_iir_bypass_2_4MHz = 1'b0; cfg_cic_bypass = 1'b0;
        cfg_cic_dec_factor = 5'd1; sts_clr = 1'b0;

        // Reset state
        repeat (3) step();
        settle();
        check("rst_core_rst_n", 32'(core_rst_n), 0);
        check("rst_src_ready", 32'(src_ready), 1);
        check("rst_factor", 32'(cic_dec_factor), 1);
        check("rst_busy", 32'(cfg_busy), 0);
        rst_n = 1'b1; src_valid = 1'b1;
        step(); settle();
        check("rel_valid_in", 32'(core_valid_in), 1);
        check("rel_core_rst_n", 32'(core_rst_n), 1);
        check("rel_bypass", 32'({frac_dec_bypass, iir_bypass_5MHz, iir_bypass_2_4MHz, cic_bypass}), 0);
        check("rel_sticky", 32'({ovf_sticky, unf_sticky}), 0);

        // Commit factor 8 with CIC bypass; core output toggles for 20 cycles
        commit(5'd8, 1'b1); settle();
        check("c8_ready_same_cycle", 32'(src_ready), 1);
        step(); cfg_commit = 1'b0; cfg_cic_bypass = 1'b0; cfg_cic_dec_factor = 5'd3; settle();
        check("c8_ready_low", 32'(src_ready), 0);
        check("c8_valid_in_low", 32'(core_valid_in), 0);
        check("c8_busy", 32'(cfg_busy), 1);
        check("c8_no_err", 32'(cfg_err), 0);
        for (int i = 0; i < 20; i++) begin
            core_valid_out = 1'(i & 1);
            step();
        end
        core_valid_out = 1'b0;
        for (int j = 1; j <= 63; j++) step();
        settle();
        check_state("c8_still_drain", DRAIN);
        check("c8_factor_old", 32'(cic_dec_factor), 1);
        step(); settle();
        check_state("c8_flush", FLUSH);
        check("c8_flush_rst", 32'(core_rst_n), 0);
        check("c8_factor_new", 32'(cic_dec_factor), 8);
        check("c8_cic_bypass", 32'(cic_bypass), 1);
        for (int k = 0; k < 3; k++) begin
            step(); settle();
            check("c8_flush_hold_rst", 32'(core_rst_n), 0);
        end
        step();
        commit(5'd3, 1'b0); settle();
        check_state("c8_release", RELEASE);
        check("c8_done", 32'(cfg_done), 1);
        check("c8_release_rst", 32'(core_rst_n), 1);
        check("c8_release_ready", 32'(src_ready), 0);
        step(); cfg_commit = 1'b0; settle();
        check_state("c8_idle", IDLE);
        check("c8_exit_commit_err", 32'(cfg_err), 1);
        check("c8_done_gone", 32'(cfg_done), 0);
        check("c8_busy_low", 32'(cfg_busy), 0);
        check("c8_ready_back", 32'(src_ready), 1);
        check("c8_factor_kept", 32'(cic_dec_factor), 8);

        // Commit factor 4; drain restart at count 50 and a rejected commit of factor 2 mid-drain
        step();
        commit(5'd4, 1'b0);
        step(); cfg_commit = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            if (j == 10) commit(5'd2, 1'b1);
            step();
            if (j == 10) begin
                cfg_commit = 1'b0; settle();
                check("c4_drain_commit_err", 32'(cfg_err), 1);
            end
        end
        core_valid_out = 1'b1;
        step(); core_valid_out = 1'b0;
        for (int j = 1; j <= 63; j++) step();
        settle();
        check_state("c4_restart_drain", DRAIN);
        step();
        core_overflow = 1'b1; settle();
        check_state("c4_flush", FLUSH);
        check("c4_factor_orig", 32'(cic_dec_factor), 4);
        check("c4_cic_bypass_off", 32'(cic_bypass), 0);
        step(); core_overflow = 1'b0; settle();
        check("c4_ovf_masked", 32'(ovf_sticky), 0);
        repeat (3) step();
        settle();
        check("c4_done", 32'(cfg_done), 1);
        step(); settle();
        check_state("c4_idle", IDLE);

        // Illegal factors are rejected in IDLE
        commit(5'd0, 1'b1);
        step(); cfg_commit = 1'b0; settle();
        check("f0_err", 32'(cfg_err), 1);
        check_state("f0_idle", IDLE);
        check("f0_ready", 32'(src_ready), 1);
        check("f0_factor", 32'(cic_dec_factor), 4);
        step(); settle();
        check("f0_err_pulse", 32'(cfg_err), 0);
        commit(5'd17, 1'b1);
        step(); cfg_commit = 1'b0; settle();
        check("f17_err", 32'(cfg_err), 1);
        check_state("f17_idle", IDLE);
        check("f17_busy", 32'(cfg_busy), 0);
        check("f17_bypass", 32'(cic_bypass), 0);

        // Sticky status: set beats clear, clear alone clears
        core_overflow = 1'b1; sts_clr = 1'b1;
        step(); core_overflow = 1'b0; settle();
        check("ovf_set_wins", 32'(ovf_sticky), 1);
        step(); sts_clr = 1'b0; settle();
        check("ovf_cleared", 32'(ovf_sticky), 0);
        core_underflow = 1'b1;
        step(); core_underflow = 1'b0; settle();
        check("unf_set", 32'(unf_sticky), 1);
        check("unf_ovf_clean", 32'(ovf_sticky), 0);

        // Reset during FLUSH aborts the commit
        commit(5'd16, 1'b1);
        step(); cfg_commit = 1'b0;
        for (int j = 1; j <= 64; j++) step();
        settle();
        check_state("ab_flush", FLUSH);
        check("ab_factor16", 32'(cic_dec_factor), 16);
        rst_n = 1'b0;
        step(); settle();
        check_state("ab_idle", IDLE);
        check("ab_factor_default", 32'(cic_dec_factor), 1);
        check("ab_bypass_default", 32'(cic_bypass), 0);
        check("ab_busy", 32'(cfg_busy), 0);
        check("ab_done", 32'(cfg_done), 0);
        check("ab_core_rst", 32'(core_rst_n), 0);
        check("ab_unf_reset", 32'(unf_sticky), 0);
        rst_n = 1'b1;
        step(); settle();
        check("ab_after_done", 32'(cfg_done), 0);
        check("ab_after_valid_in", 32'(core_valid_in), 1);
        check("ab_after_core_rst", 32'(core_rst_n), 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
